// File: rtl/dyser_cfg_loader.sv
// dyser_cfg_loader: streams a CFG_WORDS-long configuration image from a
// synchronous config ROM into the DySER fabric config port, one word per
// cycle, holding off core traffic while loading.
// Optional build macro: DYSER_CFG_CHECKSUM_EN -- fetch one extra trailing
// checksum word, XOR-check the forwarded image and report cfg_err with done.
module dyser_cfg_loader #(
  parameter int unsigned CFG_WORDS  = 17,
  parameter int unsigned CFG_WIDTH  = 21,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [CFG_WIDTH-1:0]  rom_data,
  output logic [CFG_WIDTH-1:0]  config_bits,
  output logic                  config_en,
  output logic                  busy,
  output logic                  dyser_hold,
  output logic                  done,
  output logic                  cfg_err
);

`ifdef DYSER_CFG_CHECKSUM_EN
  localparam int unsigned NFETCH = CFG_WORDS + 1;
`else
  localparam int unsigned NFETCH = CFG_WORDS;
`endif
  localparam int unsigned CNT_W = $clog2(NFETCH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  base_r;
  logic [CNT_W-1:0]       cnt;      // number of addresses issued so far
  logic                   rd_pend;  // ROM read in flight, data arrives this cycle
  logic                   cap;      // a ROM word was captured last edge
`ifdef DYSER_CFG_CHECKSUM_EN
  logic                   rd_ck;    // in-flight read is the checksum word
  logic [CFG_WIDTH-1:0]   xor_acc;
  logic [CFG_WIDTH-1:0]   ck_word;
`endif

  assign dyser_hold = busy;

  // Sequencer FSM plus the registered ROM-to-fabric data pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      base_r      <= '0;
      cnt         <= '0;
      rd_pend     <= 1'b0;
      cap         <= 1'b0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      config_bits <= '0;
      config_en   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
`ifdef DYSER_CFG_CHECKSUM_EN
      rd_ck       <= 1'b0;
      xor_acc     <= '0;
      ck_word     <= '0;
`endif
    end else begin
      done    <= 1'b0;
      rd_pend <= rom_en;
      cap     <= rd_pend;
`ifdef DYSER_CFG_CHECKSUM_EN
      // The address presented now has index cnt-1; the checksum sits at CFG_WORDS.
      rd_ck       <= rom_en && (cnt == CNT_W'(NFETCH));
      config_en   <= rd_pend && !rd_ck;
      config_bits <= (rd_pend && !rd_ck) ? rom_data : '0;
      if (rd_pend && !rd_ck) xor_acc <= xor_acc ^ rom_data;
      if (rd_pend && rd_ck)  ck_word <= rom_data;
`else
      config_en   <= rd_pend;
      config_bits <= rd_pend ? rom_data : '0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            base_r   <= base_addr;
            rom_addr <= base_addr;
            rom_en   <= 1'b1;
            cnt      <= CNT_W'(1);
            busy     <= 1'b1;
            cfg_err  <= 1'b0;
`ifdef DYSER_CFG_CHECKSUM_EN
            xor_acc  <= '0;
`endif
            state    <= S_LOAD;
          end
        end
        S_LOAD, S_DRAIN: begin
          if (abort) begin
            state       <= S_IDLE;
            rom_en      <= 1'b0;
            busy        <= 1'b0;
            rd_pend     <= 1'b0;
            cap         <= 1'b0;
            config_en   <= 1'b0;
            config_bits <= '0;
`ifdef DYSER_CFG_CHECKSUM_EN
            rd_ck       <= 1'b0;
`endif
          end else if (state == S_LOAD) begin
            if (cnt == CNT_W'(NFETCH)) begin
              rom_en <= 1'b0;
              state  <= S_DRAIN;
            end else begin
              rom_addr <= base_r + ADDR_WIDTH'(cnt);
              cnt      <= cnt + CNT_W'(1);
            end
          end else if (!rd_pend && !cap) begin
            // Leave only once the last fetched word has been captured and retired.
            done  <= 1'b1;
            state <= S_DONE;
`ifdef DYSER_CFG_CHECKSUM_EN
            cfg_err <= (xor_acc != ck_word);
`endif
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dyser_cfg_loader.sv
// Directed self-checking bench for dyser_cfg_loader with a synchronous ROM model.
module tb_dyser_cfg_loader;
  localparam int unsigned CW = 17;
  localparam int unsigned WD = 21;
  localparam int unsigned AW = 8;
`ifdef DYSER_CFG_CHECKSUM_EN
  localparam int unsigned NF   = CW + 1;
  localparam int unsigned DLAT = 21;
`else
  localparam int unsigned NF   = CW;
  localparam int unsigned DLAT = 20;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [AW-1:0] base_addr, rom_addr;
  logic          rom_en;
  logic [WD-1:0] rom_data = '0;
  logic [WD-1:0] config_bits;
  logic          config_en, busy, dyser_hold, done, cfg_err;
  logic [WD-1:0] rom [256];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  dyser_cfg_loader #(.CFG_WORDS(CW), .CFG_WIDTH(WD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .config_bits(config_bits), .config_en(config_en), .busy(busy),
    .dyser_hold(dyser_hold), .done(done), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, " rom_en"}, rom_en, 0);
    check({nm, " rom_addr"}, rom_addr, 0);
    check({nm, " config_bits"}, config_bits, 0);
    check({nm, " config_en"}, config_en, 0);
    check({nm, " busy"}, busy, 0);
    check({nm, " hold"}, dyser_hold, 0);
    check({nm, " done"}, done, 0);
    check({nm, " cfg_err"}, cfg_err, 0);
  endtask

  // kind: 0 plain, 1 re-start at word ev_at, 2 abort after word ev_at, 3 reset at word ev_at
  task automatic run_load(input logic [7:0] base, input int unsigned kind,
                          input int unsigned ev_at, input string nm);
    int unsigned nwords, naddr, ndone, first_en, done_cyc;
    logic abort_pend;
    logic exp_err;
    logic [7:0] a;
    logic [WD-1:0] x;
    nwords = 0; naddr = 0; ndone = 0; first_en = 0; done_cyc = 0;
    abort_pend = 1'b0;
    exp_err = 1'b0;
    x = '0;
`ifdef DYSER_CFG_CHECKSUM_EN
    for (int unsigned k = 0; k < CW; k++) begin
      a = base + 8'(k);
      x ^= rom[a];
    end
    a = base + 8'(CW);
    exp_err = (x != rom[a]);
`endif
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 0) begin
        check({nm, " busy@start"}, busy, 1);
        check({nm, " hold@start"}, dyser_hold, 1);
      end
      if (abort_pend) begin
        check({nm, " abort config_en"}, config_en, 0);
        check({nm, " abort busy"}, busy, 0);
        check({nm, " abort rom_en"}, rom_en, 0);
        abort = 1'b0;
        abort_pend = 1'b0;
      end
      if (rom_en) begin
        a = base + 8'(naddr);
        check({nm, " rom_addr"}, rom_addr, a);
        naddr++;
      end
      if (config_en) begin
        a = base + 8'(nwords);
        check({nm, " word"}, config_bits, rom[a]);
        if (nwords == 0) first_en = c;
        nwords++;
        if (nwords == ev_at) begin
          case (kind)
            1: begin start = 1'b1; base_addr = base ^ 8'h40; end
            2: begin abort = 1'b1; abort_pend = 1'b1; end
            3: begin
              #2 rst = 1'b0;
              #1 check_idle({nm, " async"});
              @(negedge clk);
              rst = 1'b1;
            end
            default: ;
          endcase
        end
      end else begin
        check({nm, " bits_idle"}, config_bits, 0);
      end
      if (done) begin
        ndone++;
        done_cyc = c;
        check({nm, " cfg_err@done"}, cfg_err, exp_err);
      end
    end
    check({nm, " busy_end"}, busy, 0);
    check({nm, " hold_end"}, dyser_hold, 0);
    if (kind <= 1) begin
      check({nm, " nwords"}, nwords, CW);
      check({nm, " naddr"}, naddr, NF);
      check({nm, " first_en"}, first_en, 2);
      check({nm, " ndone"}, ndone, 1);
      check({nm, " done_cyc"}, done_cyc, DLAT);
      check({nm, " cfg_err_held"}, cfg_err, exp_err);
    end else begin
      check({nm, " nwords"}, nwords, ev_at);
      check({nm, " ndone"}, ndone, 0);
    end
  endtask

  initial begin
    logic [WD-1:0] x;
    for (int i = 0; i < 256; i++) rom[i] = WD'((i * 32'h13579) ^ 32'h05A3C);
    rom[0]  = 21'h000000;
    rom[1]  = 21'h000080;
    rom[2]  = 21'h040980;
    rom[16] = 21'h000010;
`ifdef DYSER_CFG_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < int'(CW); i++) x ^= rom[i];
    rom[CW] = x;
`else
    x = '0;
`endif
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0;
    #2 rst = 1'b0;
    #1 check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_load(8'h00, 0, 0,  "ld0");
    run_load(8'hF8, 0, 0,  "wrap");
    run_load(8'h00, 1, 5,  "restart");
    run_load(8'h20, 2, 6,  "abort");
    run_load(8'h20, 0, 0,  "reload");
    run_load(8'h30, 3, 10, "rst");
    check_idle("after_rst");
    run_load(8'h00, 0, 0,  "post_rst");
`ifdef DYSER_CFG_CHECKSUM_EN
    rom[CW] = rom[CW] ^ 21'h000001;
    run_load(8'h00, 0, 0,  "ck_bad");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
